// File: rtl/cam_capture_pkg.sv
// Shared definitions for the camera capture block: resolution defaults,
// capture FSM encoding and the RGB565 color-bar palette.
package cam_capture_pkg;

  localparam int H_RES_DEF = 480;
  localparam int V_RES_DEF = 272;
  localparam int N_BARS    = 8;

  typedef enum logic [1:0] {
    S_SYNC   = 2'd0,
    S_VBLANK = 2'd1,
    S_ACTIVE = 2'd2
  } cap_state_e;

  localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
  localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB_CYAN    = 16'h07FF;
  localparam logic [15:0] RGB_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
  localparam logic [15:0] RGB_RED     = 16'hF800;
  localparam logic [15:0] RGB_BLUE    = 16'h001F;
  localparam logic [15:0] RGB_BLACK   = 16'h0000;

  // Bar order runs left to right across the line.
  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return RGB_WHITE;
      3'd1:    return RGB_YELLOW;
      3'd2:    return RGB_CYAN;
      3'd3:    return RGB_GREEN;
      3'd4:    return RGB_MAGENTA;
      3'd5:    return RGB_RED;
      3'd6:    return RGB_BLUE;
      default: return RGB_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/cam_testpat_gen.sv
// Color-bar generator: maps a pixel column to one of eight RGB565 bars.
// Compiled only when CAM_CAPTURE_TESTPAT_EN is defined.
`ifdef CAM_CAPTURE_TESTPAT_EN
module cam_testpat_gen
  import cam_capture_pkg::*;
#(
  parameter int H_RES  = H_RES_DEF,
  parameter int X_W    = 9,
  parameter int DATA_W = 16
) (
  input  logic [X_W-1:0]    i_x,
  output logic [DATA_W-1:0] o_color
);

  localparam int BAR_W = H_RES / N_BARS;

  logic [2:0] bar_idx;

  // Threshold compares instead of a divider; the last matching bar wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    bar_idx = '0;
    for (int k = 1; k < N_BARS; k++) begin
      if (i_x >= X_W'(k * BAR_W)) bar_idx = 3'(k);
    end
    o_color = DATA_W'(bar_color(bar_idx));
  end

endmodule
`endif

// File: rtl/cam_capture.sv
// Camera capture: assembles high/low byte pairs into RGB565 frame-buffer writes.
// Optional color-bar test pattern is built when CAM_CAPTURE_TESTPAT_EN is defined.
module cam_capture
  import cam_capture_pkg::*;
#(
  parameter int H_RES  = H_RES_DEF,
  parameter int V_RES  = V_RES_DEF,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 17
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cam_vsync,
  input  logic              i_cam_href,
  input  logic [7:0]        i_cam_data,
  input  logic              i_test_mode,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_vsync,
  output logic              o_frame_done,
  output logic              o_err
);

  localparam int X_W = $clog2(H_RES + 1);
  localparam int Y_W = $clog2(V_RES + 1);

  cap_state_e        state_q;
  logic              armed_q;
  logic              phase_q;
  logic [7:0]        hi_q;
  logic [X_W-1:0]    x_q;
  logic [Y_W-1:0]    y_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] line_base_q;
  logic              href_q;
  logic              vsync_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              frame_done_q;
  logic              err_q;

  logic              vs_rise;
  logic              vs_fall;
  logic              href_fall;
  logic              take_byte;
  logic              pix_in_range;
  logic [DATA_W-1:0] pix_data_d;

  assign vs_rise      = i_cam_vsync & ~vsync_q;
  assign vs_fall      = ~i_cam_vsync & vsync_q;
  assign href_fall    = href_q & ~i_cam_href;
  // A byte arriving with the VSYNC rise belongs to an aborted line.
  assign take_byte    = (state_q == S_ACTIVE) && i_cam_href && !vs_rise;
  assign pix_in_range = (x_q < X_W'(H_RES)) && (y_q < Y_W'(V_RES));

`ifdef CAM_CAPTURE_TESTPAT_EN
  logic [DATA_W-1:0] bar_color_w;

  cam_testpat_gen #(
    .H_RES  (H_RES),
    .X_W    (X_W),
    .DATA_W (DATA_W)
  ) u_testpat (
    .i_x     (x_q),
    .o_color (bar_color_w)
  );

  assign pix_data_d = i_test_mode ? bar_color_w : DATA_W'({hi_q, i_cam_data});
`else
  logic unused_test_mode;
  assign unused_test_mode = i_test_mode;
  assign pix_data_d       = DATA_W'({hi_q, i_cam_data});
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_SYNC;
      armed_q      <= 1'b0;
      phase_q      <= 1'b0;
      hi_q         <= '0;
      x_q          <= '0;
      y_q          <= '0;
      addr_q       <= '0;
      line_base_q  <= '0;
      href_q       <= 1'b0;
      vsync_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values.
      vsync_q      <= i_cam_vsync;
      href_q       <= i_cam_href;
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;

      case (state_q)
        S_SYNC: begin
          // Require VSYNC seen low first so a level held across reset is not a rise.
          if (!i_cam_vsync) armed_q <= 1'b1;
          if (armed_q && i_cam_vsync) state_q <= S_VBLANK;
        end

        S_VBLANK: begin
          if (vs_fall) begin
            state_q     <= S_ACTIVE;
            phase_q     <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            addr_q      <= '0;
            line_base_q <= '0;
          end
        end

        S_ACTIVE: begin
          if (vs_rise) begin
            state_q      <= S_VBLANK;
            frame_done_q <= 1'b1;
            phase_q      <= 1'b0;
            x_q          <= '0;
          end else if (take_byte) begin
            phase_q <= ~phase_q;
            if (!phase_q) begin
              hi_q <= i_cam_data;
            end else begin
              if (pix_in_range) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= addr_q;
                wr_data_q <= pix_data_d;
                addr_q    <= addr_q + ADDR_W'(1);
              end else begin
                err_q <= 1'b1;
              end
              if (x_q < X_W'(H_RES)) x_q <= x_q + X_W'(1);
            end
          end else if (href_fall) begin
            if (phase_q) begin
              phase_q <= 1'b0;
              err_q   <= 1'b1;
            end
            x_q <= '0;
            // Line base tracks y*H_RES by addition; short lines still land on the next row.
            if ((x_q != '0) && (y_q < Y_W'(V_RES))) begin
              y_q         <= y_q + Y_W'(1);
              line_base_q <= line_base_q + ADDR_W'(H_RES);
              addr_q      <= line_base_q + ADDR_W'(H_RES);
            end
          end
        end

        default: state_q <= S_SYNC;
      endcase
    end
  end

  assign o_wr_en      = wr_en_q;
  assign o_wr_addr    = wr_addr_q;
  assign o_wr_data    = wr_data_q;
  assign o_vsync      = vsync_q;
  assign o_frame_done = frame_done_q;
  assign o_err        = err_q;

endmodule

// File: doc/cam_capture.md
CAM_CAPTURE -- requirements
Module: cam_capture

Interface
REQ-001 Parameter H_RES, default 480, active pixels per line.
REQ-002 Parameter V_RES, default 272, active lines per frame.
REQ-003 Parameter DATA_W, default 16, RGB565 pixel width.
REQ-004 Parameter ADDR_W, default 17, frame-buffer address width (covers 480*272 = 130,560).
REQ-005 i_clk  in  1  camera pixel clock; sole clock.
REQ-006 i_rst_n  in  1  asynchronous, active-low reset.
REQ-007 i_cam_vsync  in  1  camera VSYNC; high = vertical blank.
REQ-008 i_cam_href  in  1  camera HREF; high = valid bytes on i_cam_data.
REQ-009 i_cam_data  in  8  camera byte bus, high byte of each pixel first.
REQ-010 i_test_mode  in  1  selects test pattern (only meaningful with CAM_CAPTURE_TESTPAT_EN).
REQ-011 o_wr_en  out  1  one-cycle pixel write strobe to the frame buffer.
REQ-012 o_wr_addr  out  ADDR_W  linear pixel address, y*H_RES + x.
REQ-013 o_wr_data  out  DATA_W  RGB565 pixel.
REQ-014 o_vsync  out  1  i_cam_vsync delayed to stay aligned with o_wr_*.
REQ-015 o_frame_done  out  1  one-cycle pulse at the end of each captured frame.
REQ-016 o_err  out  1  sticky: odd byte count on a line, or pixel/line overrun; cleared only by reset.

Function
REQ-017 FSM states: S_SYNC (wait for the first VSYNC rising edge), S_VBLANK, S_ACTIVE.
REQ-018 Transitions: S_SYNC→S_VBLANK on VSYNC rise; S_VBLANK→S_ACTIVE on VSYNC fall; S_ACTIVE→S_VBLANK on VSYNC rise.
REQ-019 Bytes are captured only in S_ACTIVE with i_cam_href=1; all bytes in S_SYNC/S_VBLANK are ignored.
REQ-020 Byte-phase bit toggles on each captured byte: phase0 byte → data[15:8], phase1 byte → data[7:0].
REQ-021 Pixel assembly on a phase1 byte: o_wr_en=1 exactly one cycle after that byte is sampled, with o_wr_data={hi,lo} and o_wr_addr of that pixel.
REQ-022 Address counter: cleared on entry to S_ACTIVE; +1 per written pixel; no multiplier.
REQ-023 x counter: clears on HREF falling edge.
REQ-024 y counter: increments on an HREF falling edge only if x>0.
REQ-025 Pixels with x≥H_RES or y≥V_RES are not written and set o_err.
REQ-026 An HREF falling edge with the byte phase at 1 drops the partial pixel, resets the phase to 0, and sets o_err.
REQ-027 o_frame_done pulses on the S_ACTIVE→S_VBLANK transition, in the same cycle as o_vsync rising.
REQ-028 The last pixel write of a frame never coincides with o_frame_done.
REQ-029 VSYNC rising mid-line aborts the line: no further writes, phase and x cleared.
REQ-030 o_wr_addr never exceeds H_RES*V_RES-1.

Reset
REQ-031 During reset, all outputs are 0, state=S_SYNC, and all counters and the phase bit are 0.
REQ-032 Reset mid-frame discards the frame; capture resumes only after the next full VSYNC pulse.

Configuration
REQ-033 With CAM_CAPTURE_TESTPAT_EN defined and i_test_mode=1, o_wr_data is replaced by 8 vertical color bars of width H_RES/8: white, yellow, cyan, green, magenta, red, blue, black (RGB565 0xFFFF, 0xFFE0, 0x07FF, 0x07E0, 0xF81F, 0xF800, 0x001F, 0x0000), with timing, address and strobes unchanged.
REQ-034 Without CAM_CAPTURE_TESTPAT_EN, i_test_mode is ignored and no pattern logic is synthesized.

Structure
REQ-035 The shared package holds H_RES/V_RES defaults, the state encoding, and the RGB565 color-bar constants.
REQ-036 One sub-module, cam_testpat_gen, maps x → RGB565 bar color; it is instantiated only under the macro.

Verification
REQ-037 Two frames of 480x272 with byte pairs (0x12,0x34) → 130,560 writes per frame, data 0x1234, last address 130,559, one o_frame_done per frame.
REQ-038 A line of 3 bytes → 1 write, o_err=1, next line starts at the correct y*480 address.
REQ-039 A line of 482 pixels → 480 writes on that line, o_err=1, no address >130,559.
REQ-040 VSYNC rises after 100 pixels of a line → writes stop, o_frame_done=1, next frame starts at address 0.
REQ-041 i_rst_n pulsed low mid-frame → all outputs 0 immediately; no writes until VSYNC rise then fall.
REQ-042 CAM_CAPTURE_TESTPAT_EN defined, i_test_mode=1 → x=0 writes 0xFFFF, x=60 writes 0xFFE0, x=479 writes 0x0000.
